sopc_run_ctrl: RTL

Synthesizable run controller placed between the board-level clock/reset and `min_sopc`. It is the on-chip counterpart of the simulation stimulus: it receives raw reset, stretches it into a clean core reset of fixed length, enables the core for a bounded or unbounded run, and halts the core on request or timeout while counting executed cycles. The same reset/run/stop sequence therefore holds on hardware as in simulation.

---
 rtl/sopc_run_ctrl_pkg.sv | 14 +
 rtl/sopc_run_ctrl_sat_counter.sv | 24 ++
 rtl/sopc_run_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared definitions for the sopc run controller: reset polarity
// constants and the run-controller state encoding.
package sopc_run_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    RunCtrlHold = 2'd0,
    RunCtrlRun  = 2'd1,
    RunCtrlHalt = 2'd2
  } run_state_t;

endpackage

// File: rtl/sopc_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Used both as the reset-hold timer and as the executed-cycle counter.
module sat_counter
  import sopc_run_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count up while enabled, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller between board clock/reset and min_sopc: stretches the
// raw reset into a fixed-length core reset, enables the core while
// running, and halts it on request (or on the run-cycle limit when the
// SOPC_RUN_TIMEOUT_EN macro is defined), counting executed cycles.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int RUN_CYCLES  = 100,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             restart_req,
  output logic             core_rst,
  output logic             core_ce,
  output logic [CNT_W-1:0] run_cnt,
  output logic [1:0]       state,
  output logic             done
);

  run_state_t       cur_state;
  run_state_t       nxt_state;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_en;
  logic             hold_clr;
  logic             run_en;
  logic             run_clr;
  logic             hold_last;
  logic             timeout_en;
  logic             timeout;

`ifdef SOPC_RUN_TIMEOUT_EN
  assign timeout_en = 1'b1;
`else
  assign timeout_en = 1'b0;
`endif

  // Compare in 64 bits so a narrow counter never aliases a large limit
  assign hold_last = (64'(hold_cnt) == 64'(HOLD_CYCLES - 1));
  assign timeout   = timeout_en && (64'(run_cnt) == 64'(RUN_CYCLES - 1));

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .en  (hold_en),
    .q   (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .en  (run_en),
    .q   (run_cnt)
  );

  // State register; raw reset always returns to the hold phase
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cur_state <= RunCtrlHold;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state: hold expires into run, halt/timeout stop, restart reruns
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      RunCtrlHold: if (hold_last) nxt_state = RunCtrlRun;
      RunCtrlRun:  if (halt_req || timeout) nxt_state = RunCtrlHalt;
      RunCtrlHalt: if (restart_req) nxt_state = RunCtrlHold;
      default:     nxt_state = RunCtrlHold;
    endcase
  end

  // Outputs decoded from the state register only, plus counter controls
  always_comb begin
    core_rst = (cur_state == RunCtrlHold);
    core_ce  = (cur_state == RunCtrlRun);
    done     = (cur_state == RunCtrlHalt);
    state    = cur_state;
    hold_en  = (cur_state == RunCtrlHold);
    hold_clr = (cur_state != RunCtrlHold);
    run_en   = (cur_state == RunCtrlRun);
    run_clr  = (cur_state == RunCtrlHalt) && restart_req;
  end

endmodule
